// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// states, opcodes/functs and datapath mux/ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REXEC  = 4'd3,
    S_IEXEC  = 4'd4,
    S_ALUWB  = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  localparam logic [2:0] SRCB_REG  = 3'b000;
  localparam logic [2:0] SRCB_FOUR = 3'b001;
  localparam logic [2:0] SRCB_SEXT = 3'b010;
  localparam logic [2:0] SRCB_ZEXT = 3'b011;
  localparam logic [2:0] SRCB_UPPR = 3'b100;
  localparam logic [2:0] SRCB_BOFS = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] DST_RD  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic is_r_alu(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                      FN_AND, FN_OR, FN_NOR, FN_SLT,
                      FN_SLL, FN_SRL, FN_SRA};
  endfunction

  function automatic logic is_i_alu(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_SLTI,
                      OP_ADDI, OP_ADDIU, OP_LUI};
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_REGIMM};
  endfunction

  function automatic logic [1:0] branch_type(input logic [5:0] op);
    logic [1:0] bt;
    unique case (op)
      OP_BNE:    bt = 2'b01;
      OP_BGTZ:   bt = 2'b10;
      OP_REGIMM: bt = 2'b11;
      default:   bt = 2'b00;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation and operand-B select for each controller state.
// Non-ALU states leave the ALU idle with operand B on reg B.
import mc_pkg::*;

module mc_alu_decode (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic [2:0] alu_src_b
);

  always_comb begin
    alu_ctrl  = ALU_NOP;
    alu_src_b = SRCB_REG;
    unique case (state)
      S_FETCH: begin
        alu_ctrl  = ALU_ADD;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_ctrl  = ALU_ADD;
        alu_src_b = SRCB_BOFS;
      end
      S_REXEC: begin
        unique case (funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          FN_SLL:          alu_ctrl = ALU_SLL;
          FN_SRL:          alu_ctrl = ALU_SRL;
          FN_SRA:          alu_ctrl = ALU_SRA;
          default:         alu_ctrl = ALU_NOP;
        endcase
      end
      S_IEXEC: begin
        unique case (opcode)
          OP_ANDI: begin
            alu_ctrl  = ALU_AND;
            alu_src_b = SRCB_ZEXT;
          end
          OP_ORI: begin
            alu_ctrl  = ALU_OR;
            alu_src_b = SRCB_ZEXT;
          end
          OP_SLTI: begin
            alu_ctrl  = ALU_SLT;
            alu_src_b = SRCB_SEXT;
          end
          OP_ADDI, OP_ADDIU: begin
            alu_ctrl  = ALU_ADD;
            alu_src_b = SRCB_SEXT;
          end
          OP_LUI: begin
            alu_ctrl  = ALU_ADD;
            alu_src_b = SRCB_UPPR;
          end
          default: begin
            alu_ctrl  = ALU_NOP;
            alu_src_b = SRCB_REG;
          end
        endcase
      end
      S_MEMADR: begin
        alu_ctrl  = ALU_ADD;
        alu_src_b = SRCB_SEXT;
      end
      S_BRANCH: begin
        alu_ctrl  = ALU_SUB;
        alu_src_b = SRCB_REG;
      end
      default: begin
        alu_ctrl  = ALU_NOP;
        alu_src_b = SRCB_REG;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: one datapath step per state,
// outputs decoded from state, ir and mem_ready.
import mc_pkg::*;

module mc_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  BranchType,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [3:0]  ALU_ctrl,
  output logic [1:0]  PCSource,
  output logic        instr_done,
  output logic        illegal_op
);

  state_t     state;
  state_t     dec_next;
  logic       dec_bad;
  logic       is_nop;
  logic [5:0] op;
  logic [5:0] fn;

  assign op     = ir[31:26];
  assign fn     = ir[5:0];
  assign is_nop = (ir == 32'd0);

  // is_nop is excluded from the R-type arms so the arms stay disjoint.
  always_comb begin
    dec_next = S_FETCH;
    dec_bad  = 1'b0;
    unique case (1'b1)
      is_nop:
        dec_next = S_FETCH;
      (op == OP_RTYPE) && (fn == FN_JR):
        dec_next = S_JR;
      (op == OP_RTYPE) && !is_nop && is_r_alu(fn):
        dec_next = S_REXEC;
      is_i_alu(op):
        dec_next = S_IEXEC;
      (op == OP_LW) || (op == OP_SW):
        dec_next = S_MEMADR;
      is_branch(op):
        dec_next = S_BRANCH;
      (op == OP_J):
        dec_next = S_JUMP;
      (op == OP_JAL):
        dec_next = S_JAL;
      default: begin
        dec_next = S_FETCH;
        dec_bad  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= dec_next;
        S_REXEC:  state <= S_ALUWB;
        S_IEXEC:  state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_MEMADR: state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_JAL:    state <= S_FETCH;
        S_JR:     state <= S_FETCH;
        default:  state <= S_RESET;
      endcase
    end
  end

  mc_alu_decode u_alu_decode (
    .state     (state),
    .opcode    (op),
    .funct     (fn),
    .alu_ctrl  (ALU_ctrl),
    .alu_src_b (ALUSrcB)
  );

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchType  = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RD;
    MemtoReg    = WB_ALU;
    ALUSrcA     = 1'b0;
    PCSource    = PCS_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        instr_done = is_nop || dec_bad;
        illegal_op = dec_bad;
      end
      S_REXEC, S_IEXEC, S_MEMADR: begin
        ALUSrcA = 1'b1;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = (op == OP_RTYPE) ? DST_RD : DST_RT;
        instr_done = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        RegDst     = DST_RT;
        MemtoReg   = WB_MDR;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        BranchType  = branch_type(op);
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        instr_done = 1'b1;
      end
      // Register file captures the already-incremented PC here.
      S_JAL: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        RegWrite   = 1'b1;
        RegDst     = DST_R31;
        MemtoReg   = WB_PC;
        instr_done = 1'b1;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_REGA;
        instr_done = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM for the MIPS core; replaces single-cycle decode with a state-sequenced controller.
- Drives the shared ALU, single memory port, IR/PC/register-file enables and datapath muxes one state per cycle.
- Consumes the IR contents, which the datapath latches under IRWrite, and a memory ready handshake.
- Sits between the instruction register and the datapath.

Parameters:
- none (state encoding and ALU codes live in the package).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- ir  in  32  instruction register contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch condition true.
- BranchType  out  2  00 beq, 01 bne, 10 bgtz, 11 bgez.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  latch memory data into IR.
- RegWrite  out  1  register-file write.
- RegDst  out  2  destination register: 00 rd, 01 rt, 10 r31.
- MemtoReg  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcA  out  1  0 PC, 1 reg A.
- ALUSrcB  out  3  000 reg B, 001 const 4, 010 SignExtImm, 011 ZeroExtImm, 100 UpperImm, 101 SignExtImm<<2.
- ALU_ctrl  out  4  ALU operation code.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A.
- instr_done  out  1  one-cycle pulse in the final state of every instruction.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode/funct.

Behaviour:
- Reset: reset high at a rising edge puts the state in RESET. This applies in any state, including mid-MEMRD/MEMWR waits; no pending request completes afterwards.
- In RESET every output is 0. RESET always moves to FETCH on the next edge.
- Outputs are combinational from the state register, ir and mem_ready only.
- ALU_ctrl codes: 0000 nop, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 nor, 0110 slt, 0111 sll, 1000 srl, 1001 sra.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, add, PCSource=00.
  - IRWrite and PCWrite are driven equal to mem_ready.
  - mem_ready=1 -> DECODE; else stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=101, add (branch target into ALUOut). Next state:
  - ir==0 (nop) -> FETCH with instr_done=1.
  - R-type, funct jr -> JR.
  - R-type, funct add/addu/sub/subu/and/or/nor/slt/sll/srl/sra -> REXEC.
  - andi/ori/slti/addi/addiu/lui -> IEXEC.
  - lw/sw -> MEMADR.
  - beq/bne/bgtz/bgez -> BRANCH.
  - j -> JUMP; jal -> JAL.
  - Anything else -> FETCH with illegal_op=1 and instr_done=1.
- REXEC: ALUSrcA=1, ALUSrcB=000, ALU_ctrl by funct (add/addu->0001, sub/subu->0010). -> ALUWB.
- IEXEC: ALUSrcA=1. -> ALUWB.
  - andi 011/0011; ori 011/0100; slti 010/0110; addi/addiu 010/0001; lui 100/0001.
- ALUWB: RegWrite=1, MemtoReg=00; RegDst=00 if ir[31:26]==0 else 01; instr_done=1. -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=010, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=01, MemtoReg=01, instr_done=1. -> FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then -> FETCH with instr_done=1 in that cycle.
- BRANCH: ALUSrcA=1, ALUSrcB=000, sub, PCWriteCond=1, PCSource=01, BranchType from opcode, instr_done=1. -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. -> FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10, instr_done=1. -> FETCH.
  - The register file captures the pre-update PC (already PC+4) on the same edge.
- JR: PCWrite=1, PCSource=11, instr_done=1. -> FETCH.
- Unlisted outputs are 0 in every state.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Latency with zero wait states:
  - R/I-type 4 cycles; lw 5; sw 4; branch/jump 3; nop 2.
  - Each wait cycle adds 1.

Decomposition:
- Package mc_pkg holds:
  - state enum localparams (RESET, FETCH, DECODE, REXEC, IEXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, JAL, JR; 4-bit encoding);
  - opcode/funct constants;
  - ALU_ctrl codes, ALUSrcB, PCSource, RegDst and MemtoReg encodings.
- Sub-module mc_alu_decode: combinational mapping of (state, opcode, funct) to ALU_ctrl/ALUSrcB.
- mc_control holds the state register, next-state logic and enables.

Test Plan:
- reset=1 for 2 cycles, then 0, mem_ready=1 -> all outputs 0 while in RESET; FETCH with MemRead=1 one cycle after release.
- ir=0x012A4020 (add $8,$9,$10), mem_ready=1 -> FETCH, DECODE, REXEC(ALU_ctrl=0001), ALUWB(RegWrite=1, RegDst=00); instr_done on cycle 4.
- ir=0x8D090004 (lw), mem_ready low 2 cycles in MEMRD -> MemRead/IorD=1 held 3 cycles; MEMWB with RegDst=01, MemtoReg=01; 7 cycles total.
- ir=0x0C000010 (jal), then ir=0x11090003 (beq) -> JAL: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10. BRANCH: PCWriteCond=1, BranchType=00, ALU_ctrl=0010.
- ir=0xFC000000 -> illegal_op=1 and instr_done=1 in DECODE, no RegWrite/MemWrite, back to FETCH.
- sw with mem_ready=0, reset asserted in second MEMWR cycle -> state RESET next edge, MemWrite=0 thereafter, FETCH follows.
